neureka_pe_accumulator: RTL and testbench

- Sits directly downstream of each binconv PE and consumes its registered column partial-result stream.
- Bit-serial weights arrive LSB-first, one beat per weight bit.
- Per output, the block shift-accumulates QW weight-bit beats over N input-channel iterations.
- It then emits one saturated 32-bit accumulator value on a valid/ready stream for the normquant stage.

---
 rtl/neureka_pe_accumulator_pkg.sv | 43 ++++
 rtl/neureka_pe_accumulator.sv | 152 +++++++++++++++
 tb/tb_neureka_pe_accumulator.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/neureka_pe_accumulator_pkg.sv
// Shared types, widths and the saturation helper
// for the NEUREKA PE shift-accumulator.
package neureka_package;

    localparam int unsigned PRES_WIDTH = 33;
    localparam int unsigned ACC_WIDTH  = 48;
    localparam int unsigned OUT_WIDTH  = 32;
    localparam int unsigned QW_WIDTH   = 4;
    localparam int unsigned ITER_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUTPUT
    } pe_accum_state_t;

    typedef struct packed {
        logic [QW_WIDTH-1:0]   qw;
        logic [ITER_WIDTH-1:0] n_iter;
        logic                  signed_w;
    } ctrl_pe_accum_t;

    typedef struct packed {
        logic busy;
        logic done;
    } flags_pe_accum_t;

    // Clamp a wide two's complement value into the OUT_WIDTH signed range.
    function automatic logic [OUT_WIDTH-1:0] sat_acc(
        input logic [ACC_WIDTH-1:0] acc
    );
        logic [ACC_WIDTH-OUT_WIDTH:0] hi;
        hi = acc[ACC_WIDTH-1:OUT_WIDTH-1];
        if ((&hi) || (~|hi)) begin
            return acc[OUT_WIDTH-1:0];
        end else if (acc[ACC_WIDTH-1]) begin
            return {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/neureka_pe_accumulator.sv
// Bit-serial shift-accumulator behind a binconv PE; emits one
// saturated result per job on a valid/ready stream.
module neureka_pe_accumulator
    import neureka_package::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    input  logic [QW_WIDTH-1:0]   qw_i,
    input  logic [ITER_WIDTH-1:0] n_iter_i,
    input  logic                  signed_w_i,
    input  logic [PRES_WIDTH-1:0] pres_data_i,
    input  logic                  pres_valid_i,
    output logic                  pres_ready_o,
    output logic [OUT_WIDTH-1:0]  acc_data_o,
    output logic                  acc_valid_o,
    input  logic                  acc_ready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [QW_WIDTH-1:0]   QW_ONE   = 1;
    localparam logic [ITER_WIDTH-1:0] ITER_ONE = 1;

    pe_accum_state_t       state_q, state_d;
    ctrl_pe_accum_t        ctrl_q, ctrl_d;
    flags_pe_accum_t       flags;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [QW_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
    logic [ITER_WIDTH-1:0] iter_cnt_q, iter_cnt_d;
    logic [OUT_WIDTH-1:0]  out_q, out_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;

    logic [ACC_WIDTH-1:0]  term_ext;
    logic [ACC_WIDTH-1:0]  term;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic                  last_bit;
    logic                  last_iter;
    logic                  beat;
    logic                  handshake;

    assign pres_ready_o = (state_q == ACCUM) & enable_i;
    assign beat         = pres_valid_i & pres_ready_o;
    assign handshake    = (state_q == OUTPUT) & valid_q & acc_ready_i;

    assign last_bit  = (bit_cnt_q == (ctrl_q.qw - QW_ONE));
    assign last_iter = (iter_cnt_q == (ctrl_q.n_iter - ITER_ONE));

    assign term_ext = {{(ACC_WIDTH-PRES_WIDTH){pres_data_i[PRES_WIDTH-1]}},
                       pres_data_i};
    assign term     = term_ext << bit_cnt_q;

    // The MSB weight bit carries negative weight for two's complement weights.
    assign acc_next = (ctrl_q.signed_w && last_bit) ? (acc_q - term)
                                                     : (acc_q + term);

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        acc_d      = acc_q;
        bit_cnt_d  = bit_cnt_q;
        iter_cnt_d = iter_cnt_q;
        out_d      = out_q;
        valid_d    = valid_q;
        done_d     = 1'b0;

        if (clear_i) begin
            state_d    = IDLE;
            ctrl_d     = '0;
            acc_d      = '0;
            bit_cnt_d  = '0;
            iter_cnt_d = '0;
            out_d      = '0;
            valid_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        ctrl_d.qw       = (qw_i == '0) ? QW_ONE : qw_i;
                        ctrl_d.n_iter   = (n_iter_i == '0) ? ITER_ONE
                                                           : n_iter_i;
                        ctrl_d.signed_w = signed_w_i;
                        acc_d           = '0;
                        bit_cnt_d       = '0;
                        iter_cnt_d      = '0;
                        state_d         = ACCUM;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_d = acc_next;
                        if (last_bit) begin
                            bit_cnt_d  = '0;
                            iter_cnt_d = iter_cnt_q + ITER_ONE;
                            if (last_iter) begin
                                out_d   = sat_acc(acc_next);
                                valid_d = 1'b1;
                                state_d = OUTPUT;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + QW_ONE;
                        end
                    end
                end
                OUTPUT: begin
                    if (handshake) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            acc_q      <= '0;
            bit_cnt_q  <= '0;
            iter_cnt_q <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            acc_q      <= acc_d;
            bit_cnt_q  <= bit_cnt_d;
            iter_cnt_q <= iter_cnt_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign flags.busy  = (state_q != IDLE);
    assign flags.done  = done_q;

    assign busy_o      = flags.busy;
    assign done_o      = flags.done;
    assign acc_data_o  = out_q;
    assign acc_valid_o = valid_q;

endmodule

// File: tb/tb_neureka_pe_accumulator.sv
// Table-driven, scoreboarded bench for neureka_pe_accumulator
// plus hand sequences for stall, backpressure, clear and reset.
module tb_neureka_pe_accumulator;
    import neureka_package::*;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic                  clear;
    logic                  enable;
    logic                  start;
    logic [QW_WIDTH-1:0]   qw;
    logic [ITER_WIDTH-1:0] n_iter;
    logic                  signed_w;
    logic [PRES_WIDTH-1:0] pres_data;
    logic                  pres_valid;
    logic                  pres_ready;
    logic [OUT_WIDTH-1:0]  acc_data;
    logic                  acc_valid;
    logic                  acc_ready;
    logic                  busy;
    logic                  done;

    neureka_pe_accumulator dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .clear_i      (clear),
        .enable_i     (enable),
        .start_i      (start),
        .qw_i         (qw),
        .n_iter_i     (n_iter),
        .signed_w_i   (signed_w),
        .pres_data_i  (pres_data),
        .pres_valid_i (pres_valid),
        .pres_ready_o (pres_ready),
        .acc_data_o   (acc_data),
        .acc_valid_o  (acc_valid),
        .acc_ready_i  (acc_ready),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]        qw;
        logic [15:0]       n_iter;
        logic              sw;
        logic [3:0]        nb;
        logic [7:0][32:0]  beats;
        logic [31:0]       exp;
    } vec_t;

    vec_t        vq[$];
    logic [31:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [32:0] d);
        int n = 0;
        pres_valid = 1'b1;
        pres_data  = d;
        #1;
        while (!pres_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!pres_ready) begin
            checks++;
            failures++;
            $display("FAIL beat_timeout: got ready=0 expected ready=1");
        end
        @(negedge clk);
        pres_valid = 1'b0;
    endtask

    task automatic begin_job(input logic [3:0] q, input logic [15:0] n,
                             input logic s);
        @(negedge clk);
        start    = 1'b1;
        qw       = q;
        n_iter   = n;
        signed_w = s;
        @(negedge clk);
        start    = 1'b0;
        qw       = 4'($urandom_range(0, 15));
        n_iter   = 16'($urandom_range(0, 65535));
        signed_w = 1'($urandom_range(0, 1));
        chk("busy_after_start", busy, 1);
    endtask

    // Called at the negedge right after the final beat was accepted.
    task automatic finish_job(input int hold);
        logic [31:0] e;
        chk("latency_valid", acc_valid, 1);
        chk("ready_in_output", pres_ready, 0);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        chk("acc_data", acc_data, e);
        pres_valid = 1'b1;
        pres_data  = 33'd99;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", acc_valid, 1);
            chk("hold_data", acc_data, e);
            chk("hold_no_ready", pres_ready, 0);
        end
        pres_valid = 1'b0;
        acc_ready  = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("valid_dropped", acc_valid, 0);
        chk("idle_after", busy, 0);
        @(negedge clk);
        chk("done_single", done, 0);
    endtask

    task automatic run_job(input vec_t v, input int hold);
        begin_job(v.qw, v.n_iter, v.sw);
        exp_q.push_back(v.exp);
        for (int j = 0; j < int'(v.nb); j++) begin
            send_beat(v.beats[j]);
        end
        finish_job(hold);
    endtask

    initial begin
        vec_t v;

        v = '0; v.qw = 1; v.n_iter = 1; v.nb = 1;
        v.beats[0] = 33'd5; v.exp = 32'd5; vq.push_back(v);

        v = '0; v.qw = 4; v.n_iter = 1; v.nb = 4;
        for (int j = 0; j < 4; j++) v.beats[j] = 33'd1;
        v.exp = 32'd15; vq.push_back(v);

        v.sw = 1'b1; v.exp = 32'hFFFF_FFFF; vq.push_back(v);

        v = '0; v.qw = 2; v.n_iter = 2; v.nb = 4;
        v.beats[0] = 33'd3; v.beats[1] = 33'h1_FFFF_FFFF;
        v.beats[2] = 33'd2; v.beats[3] = 33'd0;
        v.exp = 32'd3; vq.push_back(v);

        v = '0; v.qw = 8; v.n_iter = 1; v.nb = 8;
        for (int j = 0; j < 8; j++) v.beats[j] = 33'h0_8000_0000;
        v.exp = 32'h7FFF_FFFF; vq.push_back(v);

        for (int j = 0; j < 8; j++) v.beats[j] = 33'h1_8000_0000;
        v.exp = 32'h8000_0000; vq.push_back(v);

        v = '0; v.qw = 3; v.n_iter = 2; v.sw = 1'b1; v.nb = 6;
        v.beats[0] = 33'd2; v.beats[1] = 33'd1; v.beats[2] = 33'd1;
        v.beats[3] = 33'h1_FFFF_FFFD; v.beats[4] = 33'd0;
        v.beats[5] = 33'd1;
        v.exp = 32'hFFFF_FFF9; vq.push_back(v);

        v = '0; v.qw = 1; v.n_iter = 2; v.nb = 2;
        v.beats[0] = 33'h0_7FFF_FFFF; v.beats[1] = 33'd1;
        v.exp = 32'h7FFF_FFFF; vq.push_back(v);

        v.beats[0] = 33'h1_8000_0000; v.beats[1] = 33'h1_FFFF_FFFF;
        v.exp = 32'h8000_0000; vq.push_back(v);

        v.beats[0] = 33'h0_7FFF_FFFF; v.beats[1] = 33'd0;
        v.exp = 32'h7FFF_FFFF; vq.push_back(v);

        rst_ni     = 1'b0;
        clear      = 1'b0;
        enable     = 1'b1;
        start      = 1'b0;
        qw         = '0;
        n_iter     = '0;
        signed_w   = 1'b0;
        pres_data  = '0;
        pres_valid = 1'b0;
        acc_ready  = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_data", acc_data, 0);
        chk("rst_valid", acc_valid, 0);
        chk("rst_ready", pres_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_ni = 1'b1;

        foreach (vq[i]) run_job(vq[i], 0);

        run_job(vq[1], 5);

        begin_job(4'd2, 16'd1, 1'b0);
        exp_q.push_back(32'd5);
        send_beat(33'd3);
        enable     = 1'b0;
        pres_valid = 1'b1;
        pres_data  = 33'd100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_ready", pres_ready, 0);
            @(negedge clk);
        end
        enable = 1'b1;
        send_beat(33'd1);
        finish_job(0);

        begin_job(4'd4, 16'd1, 1'b0);
        send_beat(33'd1);
        send_beat(33'd1);
        clear      = 1'b1;
        start      = 1'b1;
        pres_valid = 1'b1;
        pres_data  = 33'd1;
        @(negedge clk);
        clear      = 1'b0;
        start      = 1'b0;
        pres_valid = 1'b0;
        chk("clr_busy", busy, 0);
        chk("clr_ready", pres_ready, 0);
        chk("clr_valid", acc_valid, 0);
        chk("clr_data", acc_data, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("clr_no_done", done, 0);
            chk("clr_start_lost", busy, 0);
        end

        v = '0; v.qw = 0; v.n_iter = 0; v.nb = 1;
        v.beats[0] = 33'd7; v.exp = 32'd7;
        run_job(v, 0);

        begin_job(4'd2, 16'd1, 1'b0);
        send_beat(33'd5);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_ready", pres_ready, 0);
        chk("arst_valid", acc_valid, 0);
        chk("arst_data", acc_data, 0);
        chk("arst_done", done, 0);
        @(negedge clk);
        rst_ni = 1'b1;

        run_job(vq[0], 0);

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
